// File: rtl/render_sequencer.sv
// rtl/render_sequencer.sv - VGA raster timing, per-line sprite overlap scan and animation counter
module render_sequencer #(
  parameter int PIX_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int X_W      = 10,
  parameter int Y_W      = 10,
  parameter int TILE     = 20,
  parameter int ANIM_DIV = 8,
  parameter int ANIM_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             anim_en,
  input  logic [5*Y_W-1:0] sprite_y,
  output logic [X_W-1:0]   x,
  output logic [Y_W-1:0]   y,
  output logic             toDisplay,
  output logic             hsync,
  output logic             vsync,
  output logic             pix_tick,
  output logic             frame_tick,
  output logic [4:0]       line_sprite_mask,
  output logic [ANIM_W-1:0] animation_timer
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam int FC_W    = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DONE
  } scan_state_e;

  logic [DIV_W-1:0]  div_q, div_d;
  logic [X_W-1:0]    x_q, x_d;
  logic [Y_W-1:0]    y_q, y_d;
  logic              td_q, td_d;
  logic              hs_q, hs_d;
  logic              vs_q, vs_d;
  logic              pix_tick_q, pix_tick_d;
  logic              frame_tick_q, frame_tick_d;
  logic [4:0]        mask_q, mask_d;
  logic [4:0]        scratch_q, scratch_d;
  logic [2:0]        idx_q, idx_d;
  logic [Y_W-1:0]    nl_q, nl_d;
  scan_state_e       state_q, state_d;
  logic [FC_W-1:0]   fc_q, fc_d;
  logic [ANIM_W-1:0] anim_q, anim_d;

  logic              tick;
  logic              x_wrap;
  logic              y_wrap;
  logic [Y_W-1:0]    sy_sel;
  logic              hit;

  assign tick   = (div_q == DIV_W'(PIX_DIV - 1));
  assign x_wrap = (x_q == X_W'(H_TOTAL - 1));
  assign y_wrap = (y_q == Y_W'(V_TOTAL - 1));

  // Pixel divider, raster counters and the sync/enable flags decoded from the next position
  always_comb begin
    div_d = tick ? '0 : div_q + 1'b1;
    x_d   = x_q;
    y_d   = y_q;
    if (tick) begin
      x_d = x_wrap ? '0 : x_q + 1'b1;
      if (x_wrap) begin
        y_d = y_wrap ? '0 : y_q + 1'b1;
      end
    end
    pix_tick_d   = tick;
    frame_tick_d = tick && x_wrap && y_wrap;
    td_d = (x_d < X_W'(H_ACTIVE)) && (y_d < Y_W'(V_ACTIVE));
    hs_d = !((x_d >= X_W'(H_ACTIVE + H_FP)) && (x_d < X_W'(H_ACTIVE + H_FP + H_SYNC)));
    vs_d = !((y_d >= Y_W'(V_ACTIVE + V_FP)) && (y_d < Y_W'(V_ACTIVE + V_FP + V_SYNC)));
  end

  // Select the sprite top under test and compare it against the upcoming line without wrap
  always_comb begin
    sy_sel = '0;
    case (idx_q)
      3'd0:    sy_sel = sprite_y[0*Y_W +: Y_W];
      3'd1:    sy_sel = sprite_y[1*Y_W +: Y_W];
      3'd2:    sy_sel = sprite_y[2*Y_W +: Y_W];
      3'd3:    sy_sel = sprite_y[3*Y_W +: Y_W];
      3'd4:    sy_sel = sprite_y[4*Y_W +: Y_W];
      default: sy_sel = '0;
    endcase
    hit = ({1'b0, sy_sel} <= {1'b0, nl_q}) &&
          ({1'b0, nl_q} < ({1'b0, sy_sel} + (Y_W+1)'(TILE)));
  end

  // Sprite scan FSM: scan during horizontal blank, publish the mask as the next line begins
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    scratch_d = scratch_q;
    nl_d      = nl_q;
    mask_d    = mask_q;
    if (tick) begin
      case (state_q)
        S_IDLE: begin
          if (x_d == X_W'(H_ACTIVE)) begin
            state_d   = S_SCAN;
            idx_d     = '0;
            scratch_d = '0;
            nl_d      = y_wrap ? '0 : y_q + 1'b1;
          end
        end
        S_SCAN: begin
          scratch_d[idx_q] = hit;
          idx_d            = idx_q + 1'b1;
          if (idx_q == 3'd4) begin
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          if (x_d == '0) begin
            mask_d  = scratch_q;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Animation: count enabled frames, step the animation index every ANIM_DIV of them
  always_comb begin
    fc_d   = fc_q;
    anim_d = anim_q;
    if (frame_tick_d && anim_en) begin
      if (fc_q == FC_W'(ANIM_DIV - 1)) begin
        fc_d   = '0;
        anim_d = anim_q + 1'b1;
      end else begin
        fc_d = fc_q + 1'b1;
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q        <= '0;
      x_q          <= '0;
      y_q          <= '0;
      td_q         <= 1'b0;
      hs_q         <= 1'b1;
      vs_q         <= 1'b1;
      pix_tick_q   <= 1'b0;
      frame_tick_q <= 1'b0;
      mask_q       <= '0;
      scratch_q    <= '0;
      idx_q        <= '0;
      nl_q         <= '0;
      state_q      <= S_IDLE;
      fc_q         <= '0;
      anim_q       <= '0;
    end else begin
      div_q        <= div_d;
      x_q          <= x_d;
      y_q          <= y_d;
      td_q         <= td_d;
      hs_q         <= hs_d;
      vs_q         <= vs_d;
      pix_tick_q   <= pix_tick_d;
      frame_tick_q <= frame_tick_d;
      mask_q       <= mask_d;
      scratch_q    <= scratch_d;
      idx_q        <= idx_d;
      nl_q         <= nl_d;
      state_q      <= state_d;
      fc_q         <= fc_d;
      anim_q       <= anim_d;
    end
  end

  assign x                = x_q;
  assign y                = y_q;
  assign toDisplay        = td_q;
  assign hsync            = hs_q;
  assign vsync            = vs_q;
  assign pix_tick         = pix_tick_q;
  assign frame_tick       = frame_tick_q;
  assign line_sprite_mask = mask_q;
  assign animation_timer  = anim_q;

endmodule
